// File: rtl/reg_pipe_n_if.sv
// Valid/ready stream bundle used on both sides of reg_pipe_n.
// The master drives valid/data and the slave drives ready.
interface reg_pipe_n_if #(
  parameter int N = 32
);
  logic         valid;
  logic         ready;
  logic [N-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_pipe_n.sv
// DEPTH-stage elastic pipeline register with bubble collapse, backpressure and flush.
// Optional transfer/stall counters are enabled with `define REG_PIPE_STATS_EN.
module reg_pipe_n #(
  parameter int  N     = 32,
  parameter int  DEPTH = 4,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  reg_pipe_n_if.slave    up,
  reg_pipe_n_if.master   dn,
  output logic [OW-1:0]  occupancy
`ifdef REG_PIPE_STATS_EN
  ,
  output logic [31:0]    stat_xfers,
  output logic [31:0]    stat_stalls
`endif
);

  logic [N-1:0]     data_q [DEPTH];
  logic [N-1:0]     data_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;
  logic             in_ready;

  // Advance ripples back from the output so a stalled tail still lets words close gaps.
  always_comb begin
    adv          = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & dn.ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end
  end

  always_comb begin
    in_ready = ~flush & (~v_q[0] | adv[0]);
    load     = '0;
    load[0]  = up.valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end
  end

  always_comb begin
    data_d[0] = load[0] ? up.data : data_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = load[i] ? data_q[i-1] : data_q[i];
    end
    v_d = flush ? '0 : (load | (v_q & ~adv));
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign up.ready  = in_ready;
  assign dn.valid  = v_q[DEPTH-1];
  assign dn.data   = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef REG_PIPE_STATS_EN
  logic [31:0] xfers_q;
  logic [31:0] xfers_d;
  logic [31:0] stalls_q;
  logic [31:0] stalls_d;

  // Both counters saturate and survive flush; only reset clears them.
  always_comb begin
    xfers_d  = xfers_q;
    stalls_d = stalls_q;
    if (v_q[DEPTH-1] & dn.ready & ~(&xfers_q)) begin
      xfers_d = xfers_q + 32'd1;
    end
    if (v_q[DEPTH-1] & ~dn.ready & ~(&stalls_q)) begin
      stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      xfers_q  <= '0;
      stalls_q <= '0;
    end else begin
      xfers_q  <= xfers_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_xfers  = xfers_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: doc/reg_pipe_n.md
Name: reg_pipe_n

Overview:
Parametrised N-bit, DEPTH-stage elastic pipeline register with a valid/ready handshake on both sides. It is the successor to the plain load-enabled N-bit register. It adds multi-stage delay, per-stage valid tracking, bubble collapsing, backpressure and flush. It sits between datapath blocks that need registered timing isolation and must tolerate downstream stalls without dropping data.

Parameters:
N, 32, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
flush  input  1  synchronous clear of all stage valid bits
in_valid  input  1  upstream word present
in_ready  output  1  block accepts the word this cycle
in_data  input  N  upstream data
out_valid  output  1  last stage holds a valid word
out_ready  input  1  downstream accepts this cycle
out_data  output  N  last-stage data
occupancy  output  $clog2(DEPTH+1)  count of valid stages

Behaviour:
- Reset (reset==0 at clk edge): all stage data = 0, all valid bits = 0.
  - Outputs after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1 (when flush=0).
  - Reset has priority over flush and over any transfer.
- Stage i (0=input, DEPTH-1=output) has registers data[i][N-1:0] and v[i].
- Advance rule, combinational:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For i<DEPTH-1: adv[i] = v[i] & (~v[i+1] | adv[i+1]).
  - A stage can accept a word when it is empty or is advancing in the same cycle.
- Handshakes:
  - in_ready = ~flush & (~v[0] | adv[0]).
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready is combinationally dependent on out_ready; this ready path is intentionally not registered.
- Stage update on clk edge:
  - A stage that receives a word loads its data and sets v=1.
  - A stage that advances and receives nothing clears v.
  - Data registers of empty or non-advancing stages hold their value and are never zeroed except by reset.
- Bubble collapse: a valid word moves forward whenever the next stage is empty, even while the output is stalled. Words never overtake each other.
- Latency and throughput:
  - With out_ready=1 continuously, a word accepted at edge k appears on out_data with out_valid=1 after edge k+DEPTH-1, i.e. it is transferred out DEPTH cycles after acceptance.
  - Sustained throughput is 1 word/cycle.
- Full condition: all v=1 and out_ready=0 -> in_ready=0. If out_ready=1 while full, in_ready=1 in the same cycle and one word enters while one leaves.
- Empty condition: out_valid=0; out_data shows the stale last-stage data (do not care).
- occupancy: registered population count of v[], updated each edge. Range 0..DEPTH.
- Flush (flush=1 at edge, reset=1): all v cleared and occupancy=0 after the edge.
  - in_ready=0 during flush; no input is accepted.
  - out_valid may still be 1 during the flush cycle. A simultaneous output transfer is honoured: the downstream sees that word once.
- Reset mid-operation: in-flight words are discarded. Nothing is emitted after reset deasserts until new words are accepted.

Optional Feature:
Macro REG_PIPE_STATS_EN.
- Defined:
  - Adds output stat_xfers [31:0], counting output transfers and saturating at 0xFFFFFFFF.
  - Adds output stat_stalls [31:0], counting cycles with out_valid=1 & out_ready=0, also saturating.
  - Both counters are cleared by reset only; flush does not clear them.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
All scenarios use N=32, DEPTH=4.
1. Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, occupancy=0, and no word accepted. After reset=1, in_ready=1.
2. Streaming: out_ready=1; push 0x00000001..0x00000010 back-to-back -> first out_valid 4 cycles after the first acceptance; 16 words out in order on consecutive cycles; occupancy steady at 4 mid-stream.
3. Backpressure: out_ready=0; offer 6 words 0xA0..0xA5 -> only 0xA0..0xA3 accepted, in_ready=0, occupancy=4. Then set out_ready=1 -> in_ready=1 the same cycle; output is 0xA0..0xA5 in order with no gaps.
4. Bubble collapse: out_ready=0; push 0x11, idle 1 cycle, push 0x22, idle 3 cycles -> occupancy=2, v[3]=v[2]=1. Then set out_ready=1 -> 0x11 and 0x22 emitted on consecutive cycles.
5. Flush: with occupancy=3 and out_ready=0, pulse flush for 1 cycle with in_valid=1 and in_data=0x55 -> in_ready=0 during the pulse; next cycle occupancy=0 and out_valid=0; 0x55 is never emitted.
6. Reset mid-stream: fill the pipe, then pulse reset=0 for 1 cycle -> occupancy=0, out_valid=0, out_data=0; a subsequently pushed 0x77 emerges 4 cycles later. With REG_PIPE_STATS_EN, stat_xfers=1 after it leaves.
